// File: rtl/sinc3_decimator_if.sv
// Bitstream-in / conversion-word-out bundle for the sinc3 decimator.
// master drives the sample side, slave (the filter) drives the result side.
interface sinc3_decimator_if #(
  parameter int W = 19
);
  logic         i_en;
  logic         i_clr;
  logic         i_data;
  logic [W-1:0] o_data;
  logic         o_valid;
  logic         o_busy;

  modport master (
    output i_en, i_clr, i_data,
    input  o_data, o_valid, o_busy
  );

  modport slave (
    input  i_en, i_clr, i_data,
    output o_data, o_valid, o_busy
  );
endinterface

// File: rtl/sinc3_decimator.sv
// Third-order CIC decimator: 1-bit bitstream in, one unsigned word per DECIM samples.
// o_valid 4 clocks after the window-closing sample; no backpressure, the sample strobe is never stalled.
module sinc3_decimator #(
  parameter int DECIM      = 64,
  parameter int LOG2_DECIM = 6,
  parameter int W          = 3*LOG2_DECIM+1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  sinc3_decimator_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_C1, S_C2, S_C3} state_t;

  state_t                r_state;
  state_t                w_next;

  logic [W-1:0]          r_i1, r_i2, r_i3;
  logic [W-1:0]          r_d1, r_d2, r_d3;
  logic [W-1:0]          r_s, r_t1, r_t2;
  logic [W-1:0]          r_data;
  logic                  r_valid;
  logic [1:0]            r_settle;
  logic [LOG2_DECIM-1:0] r_cnt;

  logic [W-1:0]          w_i1, w_i2, w_i3;
  logic                  w_win_done;

  // Integrator chain is combinational so the window sum includes the current sample.
  assign w_i1       = r_i1 + W'(bus.i_data);
  assign w_i2       = r_i2 + w_i1;
  assign w_i3       = r_i3 + w_i2;
  assign w_win_done = bus.i_en && (r_cnt == LOG2_DECIM'(DECIM-1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else if (bus.i_clr) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_win_done) w_next = S_C1;
      S_C1:    w_next = S_C2;
      S_C2:    w_next = S_C3;
      S_C3:    w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_i1     <= '0;
      r_i2     <= '0;
      r_i3     <= '0;
      r_d1     <= '0;
      r_d2     <= '0;
      r_d3     <= '0;
      r_s      <= '0;
      r_t1     <= '0;
      r_t2     <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_settle <= 2'd0;
      r_cnt    <= '0;
    end else if (bus.i_clr) begin
      r_i1     <= '0;
      r_i2     <= '0;
      r_i3     <= '0;
      r_d1     <= '0;
      r_d2     <= '0;
      r_d3     <= '0;
      r_s      <= '0;
      r_t1     <= '0;
      r_t2     <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_settle <= 2'd0;
      r_cnt    <= '0;
    end else begin
      r_valid <= 1'b0;
      if (bus.i_en) begin
        r_i1  <= w_i1;
        r_i2  <= w_i2;
        r_i3  <= w_i3;
        r_cnt <= r_cnt + LOG2_DECIM'(1);
        if (w_win_done) r_s <= w_i3;
      end
      // Comb stages run one per clock regardless of i_en; all differences wrap mod 2^W.
      unique case (r_state)
        S_C1: begin
          r_t1 <= r_s - r_d1;
          r_d1 <= r_s;
        end
        S_C2: begin
          r_t2 <= r_t1 - r_d2;
          r_d2 <= r_t1;
        end
        S_C3: begin
          r_data <= r_t2 - r_d3;
          r_d3   <= r_t2;
          if (r_settle == 2'd2) r_valid  <= 1'b1;
          else                  r_settle <= r_settle + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_data  = r_data;
  assign bus.o_valid = r_valid;
  assign bus.o_busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_sinc3_decimator.sv
// Directed bench for sinc3_decimator with DECIM=64: step, zero, alternating, wrap, reset and clear cases.
module tb_sinc3_decimator;
  localparam int DECIM = 64;
  localparam int W     = 19;
  localparam int FULL  = 262144;
  localparam int HALF  = 131072;

  logic i_clk;
  logic i_rst_n;
  int   cyc = 0;

  sinc3_decimator_if #(.W(W)) bus ();

  sinc3_decimator #(.DECIM(DECIM), .LOG2_DECIM(6), .W(W)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus.slave)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;
  int v_dat[$];
  int v_cyc[$];
  int end_cyc[$];
  int busy_cnt = 0;

  always @(negedge i_clk) begin
    if (bus.o_valid === 1'b1) begin
      v_dat.push_back(int'(bus.o_data));
      v_cyc.push_back(cyc);
    end
    if (bus.o_busy === 1'b1) busy_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic en, input logic d);
    @(posedge i_clk);
    #1;
    bus.i_en   = en;
    bus.i_data = d;
    bus.i_clr  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic clear_mon();
    v_dat.delete();
    v_cyc.delete();
    end_cyc.delete();
    busy_cnt = 0;
  endtask

  task automatic do_reset();
    @(posedge i_clk);
    #1;
    bus.i_en  = 1'b0;
    bus.i_clr = 1'b0;
    i_rst_n   = 1'b0;
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
  endtask

  // mode 0: all ones, 1: all zeros, 2: alternating starting with 1
  task automatic run_win(input int n_win, input int mode, input int gap);
    logic d;
    for (int s = 1; s <= n_win*DECIM; s++) begin
      for (int g = 1; g < gap; g++) step(1'b0, 1'b0);
      d = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : ((s % 2) == 1);
      step(1'b1, d);
      if ((s % DECIM) == 0) end_cyc.push_back(cyc);
    end
  endtask

  task automatic check_run(input string tag, input int exp_n, input int exp_val);
    chk({tag, "_count"}, v_dat.size(), exp_n);
    for (int k = 0; k < v_dat.size() && k < exp_n; k++) begin
      chk({tag, "_data"}, v_dat[k], exp_val);
      if (k + 2 < end_cyc.size())
        chk({tag, "_latency"}, v_cyc[k], end_cyc[k+2] + 4);
    end
  endtask

  initial begin
    i_rst_n     = 1'b0;
    bus.i_en    = 1'b0;
    bus.i_clr   = 1'b0;
    bus.i_data  = 1'b0;
    #12;
    chk("rst_o_data",  bus.o_data,  0);
    chk("rst_o_valid", bus.o_valid, 0);
    chk("rst_o_busy",  bus.o_busy,  0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;

    // 1: step input, 4 windows
    clear_mon();
    run_win(4, 0, 1);
    idle(8);
    check_run("ones4", 2, FULL);

    // 2: zeros, 5 windows
    do_reset();
    clear_mon();
    run_win(5, 1, 1);
    idle(8);
    check_run("zeros5", 3, 0);
    chk("zeros5_busy_cycles", busy_cnt, 15);

    // 3: alternating with sparse strobe
    do_reset();
    clear_mon();
    run_win(6, 2, 3);
    idle(8);
    check_run("alt6", 4, HALF);
    for (int k = 0; k + 1 < v_cyc.size(); k++)
      chk("alt6_spacing", v_cyc[k+1] - v_cyc[k], 192);

    // 4: long run, integrators wrap
    do_reset();
    clear_mon();
    run_win(10, 0, 1);
    idle(8);
    check_run("ones10", 8, FULL);

    // 5: async reset while comb is in C2
    do_reset();
    clear_mon();
    run_win(3, 0, 1);
    idle(8);
    for (int s = 0; s < DECIM; s++) step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("c2_busy", bus.o_busy, 1);
    chk("c2_o_data_before", bus.o_data, FULL);
    i_rst_n = 1'b0;
    #1;
    chk("c2_rst_o_data",  bus.o_data,  0);
    chk("c2_rst_o_valid", bus.o_valid, 0);
    chk("c2_rst_o_busy",  bus.o_busy,  0);
    idle(3);
    i_rst_n = 1'b1;
    idle(8);
    chk("c2_rst_no_valid", v_dat.size(), 1);
    clear_mon();
    run_win(3, 0, 1);
    idle(8);
    check_run("after_rst", 1, FULL);

    // 6: clear coincident with window-closing sample
    do_reset();
    clear_mon();
    run_win(3, 0, 1);
    idle(8);
    for (int s = 0; s < DECIM - 1; s++) step(1'b1, 1'b1);
    @(posedge i_clk);
    #1;
    bus.i_en   = 1'b1;
    bus.i_data = 1'b1;
    bus.i_clr  = 1'b1;
    busy_cnt   = 0;
    idle(8);
    chk("clr_no_busy",  busy_cnt, 0);
    chk("clr_o_data",   bus.o_data, 0);
    chk("clr_no_valid", v_dat.size(), 1);
    clear_mon();
    run_win(3, 0, 1);
    idle(8);
    check_run("after_clr", 1, FULL);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sinc3_decimator.md
Name: sinc3_decimator

Overview:
Third-order CIC (sinc3) decimation filter for the iCESDM bitstream. It consumes the 1-bit modulator bitstream, typically the serial output of the modulator's delay/shift stage, qualified by the same sample-enable strobe. It produces one unsigned multi-bit conversion word per DECIM input samples, with a one-cycle valid pulse. It sits directly downstream of the bitstream shift stage and feeds the readout/UART logic.

Parameters:
DECIM, 64, decimation ratio; power of two, 4..1024.
LOG2_DECIM, 6, log2(DECIM); must match DECIM.
W, 3*LOG2_DECIM+1 (19), internal and output width.

Ports:
i_clk  in  1  system clock; all logic on rising edge.
i_rst_n  in  1  asynchronous active-low reset.
i_en  in  1  sample strobe; one bitstream sample is consumed per cycle with i_en=1.
i_clr  in  1  synchronous clear; same effect as reset, honoured regardless of i_en.
i_data  in  1  bitstream sample; 1 maps to +1, 0 maps to 0.
o_data  out  W  filtered, decimated word, unsigned; range 0..DECIM^3.
o_valid  out  1  one-cycle pulse when o_data updates.
o_busy  out  1  high while the comb FSM is not IDLE.

Behaviour:
- Reset and clear:
  - Reset is asynchronous, active-low. i_clr is synchronous and has priority over i_en.
  - Both zero the integrators I1..I3, comb delays D1..D3, decimation counter, settle counter and FSM (to IDLE).
  - Outputs after reset/clear: o_data=0, o_valid=0, o_busy=0.
  - Reset or clear mid-FSM aborts the comb; no o_valid is issued for the aborted word.
- Integrators:
  - On each i_en cycle: I1+=i_data, I2+=I1_new, I3+=I2_new.
  - The chain is combinational within the cycle, so I3 includes the current sample.
  - All arithmetic is W-bit modulo 2^W. Wrap-around is intended and must not saturate.
- Decimation counter:
  - 0..DECIM-1, increments on i_en.
  - On i_en with count==DECIM-1: wrap to 0, latch S<=I3_new, and FSM IDLE->C1.
- Comb FSM: IDLE -> C1 -> C2 -> C3 -> IDLE, one state per clock, independent of i_en.
  - C1: T1 = S - D1; D1 <= S.
  - C2: T2 = T1 - D2; D2 <= T1.
  - C3: Y = T2 - D3; D3 <= T2; o_data <= Y.
  - On exit from C3: o_valid pulses for one cycle, unless suppressed by the settle counter.
  - All subtractions are W-bit modulo.
- Latency: o_valid is high exactly 4 clocks after the i_en cycle that completed the decimation window.
- o_busy is high in C1..C3.
- Settle suppression:
  - The first 2 comb results after reset/clear update D1..D3 and o_data but do not pulse o_valid.
  - The 3rd and later results pulse o_valid.
  - The settle counter saturates at 2.
- o_data holds its value between updates.
- Overlap cannot occur because DECIM>=4: a new decimation event always lands after C3. An i_en during C1..C3 is still consumed normally by the integrators.
- i_en=0 freezes the integrators and the decimation counter only; an FSM already running completes.

Test Plan:
1. Reset, then constant i_data=1 with i_en every cycle for 4*64 samples -> o_valid pulses twice (2 suppressed), both o_data=262144 (0x40000), each exactly 4 clocks after samples 192 and 256.
2. Constant i_data=0 for 5 windows -> three o_valid pulses, all o_data=0; o_busy high 3 cycles per window.
3. Alternating 1,0,1,0 (starting 1), i_en every 3rd clock, 6 windows -> four valid outputs, each 131072 (0x20000); spacing 192 clocks.
4. Run all-ones for 10 windows (I3 wraps many times) -> every valid o_data remains 262144, proving modulo arithmetic.
5. Assert i_rst_n low while the FSM is in C2 -> outputs immediately 0, no o_valid. Restart with all-ones -> first valid on the 3rd window, value 262144.
6. Pulse i_clr in the same cycle as a window-completing i_en -> no FSM start, counter=0, o_data=0. Next windows are settle-suppressed as after reset.
